// File: rtl/wb_bram_bridge.sv
// wb_bram_bridge: Wishbone slave over a byte-writable word memory with
// independent read/write wait states, window/alignment error response and access counters.
module wb_bram_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
   parameter int          ADDR_W    = 10,
   parameter int          RD_DELAY  = 10,
   parameter int          WR_DELAY  = 10,
   parameter int          CNT_W     = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic             wbs_err_o,
   output logic [31:0]      wbs_dat_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] rd_cnt_o,
   output logic [CNT_W-1:0] wr_cnt_o
);
   // 33-bit limit so a window ending at 4 GiB does not wrap
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
   localparam logic [7:0]  RD_D  = 8'(RD_DELAY);
   localparam logic [7:0]  WR_D  = 8'(WR_DELAY);
   typedef enum logic [2:0] {IDLE, WAIT, MEM, ACK, ERR} state_t;
   state_t state, next;
   logic [31:0] adr_q, dat_q;
   logic [3:0] sel_q;
   logic we_q, req, bad;
   logic [7:0] cnt, dly_in, dly_q;
   logic [ADDR_W-1:0] idx;
   logic [31:0] mem [2**ADDR_W];
   assign req    = wbs_cyc_i & wbs_stb_i;
   assign bad    = (wbs_adr_i[1:0] != 2'b00) || (wbs_adr_i < BASE_ADDR) || ({1'b0, wbs_adr_i} >= LIMIT);
   assign dly_in = wbs_we_i ? WR_D : RD_D;
   assign dly_q  = we_q ? WR_D : RD_D;
   assign idx    = ADDR_W'((adr_q - BASE_ADDR) >> 2);
   assign busy_o = state != IDLE;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = !req ? IDLE : bad ? ERR : (dly_in == 8'd0) ? MEM : WAIT;
         WAIT:    next = !wbs_cyc_i ? IDLE : (cnt == dly_q - 8'd1) ? MEM : WAIT;
         MEM:     next = ACK;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         wbs_ack_o <= 1'b0;
         wbs_err_o <= 1'b0;
         wbs_dat_o <= 32'd0;
         rd_cnt_o  <= '0;
         wr_cnt_o  <= '0;
         adr_q     <= 32'd0;
         dat_q     <= 32'd0;
         sel_q     <= 4'd0;
         we_q      <= 1'b0;
      end else begin
         state     <= next;
         cnt       <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
         wbs_ack_o <= next == ACK;
         wbs_err_o <= next == ERR;
         if (state == IDLE && req) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            sel_q <= wbs_sel_i;
            we_q  <= wbs_we_i;
         end
         if (state == MEM && !we_q) wbs_dat_o <= mem[idx];
         if (state == MEM && !we_q && !(&rd_cnt_o)) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
         if (state == MEM && we_q && !(&wr_cnt_o)) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
      end
   end
   // memory is deliberately outside the reset domain
   always_ff @(posedge wb_clk_i) begin
      if (state == MEM && we_q)
         for (int i = 0; i < 4; i++)
            if (sel_q[i]) mem[idx][8*i +: 8] <= dat_q[8*i +: 8];
   end
endmodule

// File: tb/tb_wb_bram_bridge.sv
// tb_wb_bram_bridge: directed checks of the default bridge and a short-delay, 2-bit-counter variant.
module tb_wb_bram_bridge;
   logic clk = 1'b0, rst = 1'b1, pick = 1'b0;
   logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0] sel = 4'd0;
   logic [31:0] adr = 32'd0, dat = 32'd0;
   logic ack_a, err_a, busy_a, ack_b, err_b, busy_b;
   logic [31:0] dat_a, dat_b;
   logic [15:0] rd_a, wr_a;
   logic [1:0] rd_b, wr_b;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   wb_bram_bridge u_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc & ~pick), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_a), .wbs_err_o(err_a),
      .wbs_dat_o(dat_a), .busy_o(busy_a), .rd_cnt_o(rd_a), .wr_cnt_o(wr_a));
   wb_bram_bridge #(.RD_DELAY(0), .WR_DELAY(3), .CNT_W(2)) u_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc & pick), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_b), .wbs_err_o(err_b),
      .wbs_dat_o(dat_b), .busy_o(busy_b), .rd_cnt_o(rd_b), .wr_cnt_o(wr_b));
   wire ack = pick ? ack_b : ack_a;
   wire err = pick ? err_b : err_a;
   wire busy = pick ? busy_b : busy_a;
   wire [31:0] rdat = pick ? dat_b : dat_a;
   wire [15:0] rd_cnt = pick ? {14'd0, rd_b} : rd_a;
   wire [15:0] wr_cnt = pick ? {14'd0, wr_b} : wr_a;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // one request; n = edges after acceptance at which the master samples ack/err
   task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int exp_n, input logic exp_err);
      int n;
      logic got_ack, got_err;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      @(posedge clk);
      n = 0; got_ack = 1'b0; got_err = 1'b0;
      while (!got_ack && !got_err && n < 100) begin
         @(negedge clk);
         n++;
         got_ack = ack;
         got_err = err;
      end
      cyc = 1'b0; stb = 1'b0;
      chk({tag, "_lat"}, n, exp_n);
      chk({tag, "_resp"}, {got_ack, got_err}, exp_err ? 32'd1 : 32'd2);
      @(negedge clk);
      chk({tag, "_single"}, {ack, err}, 32'd0);
   endtask
   initial begin
      logic seen;
      repeat (3) @(negedge clk);
      chk("rst_out", {ack, err, busy}, 32'd0);
      chk("rst_dat", rdat, 32'd0);
      chk("rst_cnt", {rd_cnt, wr_cnt}, 32'd0);
      rst = 1'b0;
      xfer("wr4", 1'b1, 32'h3800_0004, 32'hA5A5_1234, 4'hF, 12, 1'b0);
      chk("wr4_cnt", wr_cnt, 32'd1);
      xfer("rd4", 1'b0, 32'h3800_0004, 32'h0, 4'hF, 12, 1'b0);
      chk("rd4_dat", rdat, 32'hA5A5_1234);
      chk("rd4_cnt", {rd_cnt, wr_cnt}, {16'd1, 16'd1});
      xfer("wr0", 1'b1, 32'h3800_0000, 32'h1111_1111, 4'hF, 12, 1'b0);
      xfer("wr0b", 1'b1, 32'h3800_0000, 32'h0000_BB00, 4'b0010, 12, 1'b0);
      xfer("rd0", 1'b0, 32'h3800_0000, 32'h0, 4'hF, 12, 1'b0);
      chk("rd0_dat", rdat, 32'h1111_BB11);
      xfer("wrtop", 1'b1, 32'h3800_0FFC, 32'hCAFE_0001, 4'hF, 12, 1'b0);
      xfer("rdtop", 1'b0, 32'h3800_0FFC, 32'h0, 4'hF, 12, 1'b0);
      chk("rdtop_dat", rdat, 32'hCAFE_0001);
      chk("cnt_pre_err", {rd_cnt, wr_cnt}, {16'd3, 16'd4});
      xfer("err_hi", 1'b0, 32'h3800_1000, 32'h0, 4'hF, 1, 1'b1);
      xfer("err_lo", 1'b1, 32'h37FF_FFFC, 32'h0, 4'hF, 1, 1'b1);
      xfer("err_mis", 1'b1, 32'h3800_0002, 32'h0, 4'hF, 1, 1'b1);
      chk("err_dat", rdat, 32'hCAFE_0001);
      chk("err_cnt", {rd_cnt, wr_cnt}, {16'd3, 16'd4});
      xfer("sel0", 1'b1, 32'h3800_0000, 32'hFFFF_FFFF, 4'h0, 12, 1'b0);
      chk("sel0_cnt", wr_cnt, 32'd5);
      xfer("rd0c", 1'b0, 32'h3800_0000, 32'h0, 4'hF, 12, 1'b0);
      chk("rd0c_dat", rdat, 32'h1111_BB11);
      xfer("wr8", 1'b1, 32'h3800_0008, 32'h0BAD_F00D, 4'hF, 12, 1'b0);
      // abort: cyc dropped after five WAIT cycles
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0008; dat = 32'hDEAD_BEEF; sel = 4'hF;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("abort_busy", busy, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         seen = seen | ack | err;
      end
      chk("abort_noresp", seen, 32'd0);
      chk("abort_idle", busy, 32'd0);
      chk("abort_cnt", wr_cnt, 32'd6);
      xfer("rd8", 1'b0, 32'h3800_0008, 32'h0, 4'hF, 12, 1'b0);
      chk("rd8_dat", rdat, 32'h0BAD_F00D);
      // reset during WAIT of a write
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0008; dat = 32'hFFFF_FFFF; sel = 4'hF;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_out", {ack, err, busy}, 32'd0);
      chk("mrst_dat", rdat, 32'd0);
      chk("mrst_cnt", {rd_cnt, wr_cnt}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      xfer("rd8r", 1'b0, 32'h3800_0008, 32'h0, 4'hF, 12, 1'b0);
      chk("rd8r_dat", rdat, 32'h0BAD_F00D);
      chk("rd8r_cnt", {rd_cnt, wr_cnt}, {16'd1, 16'd0});
      // short-delay variant with saturating 2-bit counters
      pick = 1'b1;
      xfer("b_wr", 1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF, 5, 1'b0);
      xfer("b_rd1", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 1'b0);
      chk("b_rd1_dat", rdat, 32'h1234_5678);
      xfer("b_rd2", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 1'b0);
      xfer("b_rd3", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 1'b0);
      chk("b_cnt3", rd_cnt, 32'd3);
      xfer("b_rd4", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 1'b0);
      xfer("b_rd5", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 1'b0);
      chk("b_sat", {rd_cnt, wr_cnt}, {16'd3, 16'd1});
      xfer("b_err", 1'b0, 32'h3800_0011, 32'h0, 4'hF, 1, 1'b1);
      chk("b_err_cnt", rd_cnt, 32'd3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
